// File: rtl/disp_arb_pkg.sv
// -----------------------------------------------------------------------------
// disp_arb_pkg
// Shared types and constants for the two-requester display arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OWN0, OWN1)
//   REQ0 / REQ1 : requester index constants (bit positions in req / gnt)
//   VALUE_W     : width of a display value (4 hex digits)
// -----------------------------------------------------------------------------
package disp_arb_pkg;

    localparam int VALUE_W = 16;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/display_arbiter_slice_timer.sv
// -----------------------------------------------------------------------------
// slice_timer
// Counts cycles of display ownership and flags when the owner has held the
// display for SLICE_CYCLES cycles. The count saturates, so a lone owner can
// keep the display indefinitely and the flag simply stays high.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   i_clear   in   restart the count at 0 (takes priority over i_enable)
//   i_enable  in   count one cycle of ownership
//   o_expired out  count has reached SLICE_CYCLES
// -----------------------------------------------------------------------------
module slice_timer #(
    parameter int unsigned SLICE_CYCLES = 24_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Widened to 64 bits so SLICE_CYCLES = 2^32-1 does not wrap before $clog2.
    localparam int CNT_W = $clog2(64'(SLICE_CYCLES) + 64'd1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SLICE_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Shares one 4-digit display between two requesters. A requester keeps the
// display while it asserts req; when both want it, the owner is preempted
// after SLICE_CYCLES cycles of ownership. Simultaneous requests from IDLE are
// resolved by a round-robin pointer.
//
// Build option: define DISP_ARB_HOLD_LAST_EN to keep showing the previous
// owner's last value while idle; otherwise the display is blanked to 0000 on
// the edge that enters IDLE.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset (release clean to clk)
//   req[1:0]     in   level-sensitive request, bit i from requester i
//   value0       in   hex value offered by requester 0
//   value1       in   hex value offered by requester 1
//   gnt[1:0]     out  one-hot-or-zero grant, registered
//   value        out  value for the display driver, registered
//   busy         out  high whenever any gnt bit is high
//   o_dbg_state  out  current FSM state, for observation only
//
// Handshake: req is a level, not a pulse. A requester owns the display from
// the edge on which its gnt bit rises until it drops req (or is preempted);
// gnt follows req with one cycle of latency and never shows 2'b11.
// -----------------------------------------------------------------------------
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned SLICE_CYCLES = 24_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [VALUE_W-1:0] value0,
    input  logic [VALUE_W-1:0] value1,
    output logic [1:0]         gnt,
    output logic [VALUE_W-1:0] value,
    output logic               busy,
    output arb_state_t         o_dbg_state
);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [1:0]         r_gnt;
    logic               r_busy;
    logic [VALUE_W-1:0] r_value;
    logic               r_ptr;       // 0: requester 0 wins a tie, 1: requester 1
    logic               w_expired;
    logic               w_clear;
    logic               w_enable;

    // Next-state decision. Preemption needs own req still high, the other
    // requester waiting and the slice used up; a dropped req hands off at once.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                case (req)
                    2'b01:   w_next = OWN0;
                    2'b10:   w_next = OWN1;
                    2'b11:   w_next = r_ptr ? OWN1 : OWN0;
                    default: w_next = IDLE;
                endcase
            end
            OWN0: begin
                if (!req[REQ0]) begin
                    w_next = req[REQ1] ? OWN1 : IDLE;
                end else if (req[REQ1] && w_expired) begin
                    w_next = OWN1;
                end
            end
            OWN1: begin
                if (!req[REQ1]) begin
                    w_next = req[REQ0] ? OWN0 : IDLE;
                end else if (req[REQ0] && w_expired) begin
                    w_next = OWN0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Every entry into an owner state (from IDLE or from the other owner)
    // starts a fresh slice.
    assign w_clear  = (w_next != r_state) && (w_next != IDLE);
    assign w_enable = (r_state != IDLE);

    slice_timer #(
        .SLICE_CYCLES (SLICE_CYCLES)
    ) u_slice_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_value <= '0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt   <= (w_next == OWN0) ? 2'b01 :
                       (w_next == OWN1) ? 2'b10 : 2'b00;
            r_busy  <= (w_next != IDLE);

            // A fresh grant to one requester gives the next tie to the other.
            if ((w_next == OWN0) && (r_state != OWN0)) begin
                r_ptr <= 1'b1;
            end else if ((w_next == OWN1) && (r_state != OWN1)) begin
                r_ptr <= 1'b0;
            end

            // Value follows the current owner one cycle late, so the edge
            // that grants still shows the previous content.
`ifdef DISP_ARB_HOLD_LAST_EN
            if (r_state == OWN0) begin
                r_value <= value0;
            end else if (r_state == OWN1) begin
                r_value <= value1;
            end
`else
            if (w_next == IDLE) begin
                r_value <= '0;
            end else if (r_state == OWN0) begin
                r_value <= value0;
            end else if (r_state == OWN1) begin
                r_value <= value1;
            end
`endif
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign value       = r_value;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
// Directed, table-driven bench for display_arbiter with SLICE_CYCLES = 4.
// Honours DISP_ARB_HOLD_LAST_EN for the expected idle display value.
// -----------------------------------------------------------------------------
module tb_display_arbiter;
    import disp_arb_pkg::*;

    localparam int unsigned SLICE = 4;

`ifdef DISP_ARB_HOLD_LAST_EN
    localparam logic [15:0] IDLE_3333 = 16'h3333;
    localparam logic [15:0] IDLE_5A5A = 16'h5A5A;
`else
    localparam logic [15:0] IDLE_3333 = 16'h0000;
    localparam logic [15:0] IDLE_5A5A = 16'h0000;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] value0;
    logic [15:0] value1;
    logic [1:0]  gnt;
    logic [15:0] value;
    logic        busy;
    arb_state_t  dbg_state;

    always #5 clk = ~clk;

    display_arbiter #(
        .SLICE_CYCLES (SLICE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .value0      (value0),
        .value1      (value1),
        .gnt         (gnt),
        .value       (value),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [1:0] exp_gnt,
                                 input logic [15:0] exp_value);
        check({name, ".gnt"},   {14'b0, gnt},  {14'b0, exp_gnt});
        check({name, ".busy"},  {15'b0, busy}, {15'b0, (exp_gnt != 2'b00)});
        check({name, ".value"}, value,         exp_value);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
        req    = r;
        value0 = a;
        value1 = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 16'h0000, 16'h0000);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  req;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [1:0]  gnt;
        logic [15:0] value;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Each row is one clock edge; expected outputs are after that edge.
        vecs[0]  = '{2'b01, 16'h1234, 16'h0000, 2'b01, 16'h0000,  "grant0"};
        vecs[1]  = '{2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234,  "val0_lat"};
        vecs[2]  = '{2'b01, 16'hABCD, 16'h0000, 2'b01, 16'hABCD,  "val0_track"};
        vecs[3]  = '{2'b10, 16'hABCD, 16'h1111, 2'b10, 16'hABCD,  "drop_handoff"};
        vecs[4]  = '{2'b10, 16'hABCD, 16'h1111, 2'b10, 16'h1111,  "own1_val"};
        vecs[5]  = '{2'b11, 16'h3333, 16'h2222, 2'b10, 16'h2222,  "both_c1"};
        vecs[6]  = '{2'b11, 16'h3333, 16'h2222, 2'b10, 16'h2222,  "both_c2"};
        vecs[7]  = '{2'b11, 16'h3333, 16'h2222, 2'b10, 16'h2222,  "both_c3"};
        vecs[8]  = '{2'b11, 16'h3333, 16'h2222, 2'b01, 16'h2222,  "preempt1"};
        vecs[9]  = '{2'b11, 16'h3333, 16'h2222, 2'b01, 16'h3333,  "own0_after"};
        vecs[10] = '{2'b00, 16'h3333, 16'h2222, 2'b00, IDLE_3333, "to_idle"};
        vecs[11] = '{2'b00, 16'h3333, 16'h2222, 2'b00, IDLE_3333, "idle_hold"};
        vecs[12] = '{2'b11, 16'h3333, 16'h4444, 2'b10, IDLE_3333, "rr_tie"};
        vecs[13] = '{2'b11, 16'h3333, 16'h4444, 2'b10, 16'h4444,  "rr_val"};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive(2'b00, 16'h0000, 16'h0000);
        #2;
        check_outputs("reset", 2'b00, 16'h0000);
        check("reset.state", {14'b0, dbg_state}, {14'b0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            step();
            check_outputs("idle", 2'b00, 16'h0000);
        end

        // Table: grant, value tracking, drop-handoff, slice restart,
        // preemption, return to idle, round-robin tie.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].req, vecs[i].v0, vecs[i].v1);
            step();
            check_outputs(vecs[i].name, vecs[i].gnt, vecs[i].value);
        end

        // Tie after reset goes to requester 0, then alternating slices.
        do_reset();
        drive(2'b11, 16'h0001, 16'h0002);
        step();
        check("rr_reset.gnt", {14'b0, gnt}, 16'h0001);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0001);
        for (int i = 0; i < 5; i++) exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0001);
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            step();
            check("slice.gnt", {14'b0, gnt}, e);
        end

        // Owner 1 drops to idle: idle display value depends on build option.
        do_reset();
        drive(2'b10, 16'h0000, 16'h5A5A);
        step();
        check("own1.gnt", {14'b0, gnt}, 16'h0002);
        step();
        check("own1.value", value, 16'h5A5A);
        drive(2'b00, 16'h0000, 16'h5A5A);
        step();
        check_outputs("own1_idle", 2'b00, IDLE_5A5A);
        step();
        step();
        check("own1_idle_later.value", value, IDLE_5A5A);

        // Asynchronous reset mid-ownership, then restart with a tie.
        do_reset();
        drive(2'b10, 16'h0000, 16'h1357);
        step();
        step();
        check("pre_rst.value", value, 16'h1357);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 2'b00, 16'h0000);
        drive(2'b11, 16'h0000, 16'h1357);
        step();
        check("in_rst.gnt", {14'b0, gnt}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst.gnt", {14'b0, gnt}, 16'h0001);
        check("post_rst.state", {14'b0, dbg_state}, {14'b0, OWN0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: SLICE_CYCLES, default 24_000_000, minimum cycles an owner keeps the display before preemption by a waiting requester; legal range 1..2^32-1.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  2  display request, bit i from requester i, level-sensitive.
REQ-005 value0  input  16  hex value offered by requester 0.
REQ-006 value1  input  16  hex value offered by requester 1.
REQ-007 gnt  output  2  one-hot-or-zero grant, bit i = requester i owns display.
REQ-008 value  output  16  value for the 4-digit display driver (connects to display.value).
REQ-009 busy  output  1  high whenever any gnt bit is high.

Function
REQ-010 FSM states IDLE, OWN0, OWN1; gnt = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE; busy = |gnt.
REQ-011 IDLE: req=01 -> OWN0; req=10 -> OWN1; req=11 -> state selected by round-robin pointer; req=00 -> stay.
REQ-012 Grant latency: gnt asserts on the first rising edge after req is sampled high in IDLE (1 cycle).
REQ-013 Slice counter clears to 0 on entry to any OWNx state and increments each cycle in OWNx, saturating at SLICE_CYCLES.
REQ-014 OWNx, own req drops: next state OWN(other) if other req high, else IDLE; no minimum hold applies.
REQ-015 OWNx, own req high, other req high, counter == SLICE_CYCLES: next state OWN(other) (preemption).
REQ-016 OWNx, own req high, other req low: stay regardless of counter.
REQ-017 Owner-to-owner handoff takes exactly one edge; gnt never has both bits high and never passes through 00 on a handoff.
REQ-018 Round-robin pointer: on every grant to requester i, pointer := other requester; pointer used only for simultaneous requests from IDLE.
REQ-019 value registered: each cycle value := value0 in OWN0, value1 in OWN1; tracks the owner's live value with 1-cycle latency.
REQ-020 In IDLE, value per REQ-026/027.

Reset
REQ-021 rst_n low: state=IDLE, gnt=00, busy=0, value=16'h0000, counter=0, pointer=requester 0, immediately (asynchronous).
REQ-022 Reset asserted mid-ownership aborts the slice; after release, arbitration restarts from IDLE, first edge after deassert samples req.
REQ-023 rst_n release synchronised by the parent; block assumes deassert is clean to clk.

Configuration
REQ-024 Macro DISP_ARB_HOLD_LAST_EN selects idle display behaviour.
REQ-025 Macro affects only value in IDLE; FSM, gnt, busy identical either way.
REQ-026 Defined: in IDLE value holds last value shown by the previous owner.
REQ-027 Undefined: in IDLE value := 16'h0000 on the edge entering IDLE.

Structure
REQ-028 Package disp_arb_pkg: state enum (IDLE, OWN0, OWN1), requester index constants REQ0/REQ1, VALUE_W=16.
REQ-029 Counter width = $clog2(SLICE_CYCLES+1), computed locally.
REQ-030 One sub-module slice_timer (clear, enable, SLICE_CYCLES parameter, expired output); FSM and value mux in display_arbiter.

Verification (bench SLICE_CYCLES=4)
REQ-031 Reset, req=00 -> gnt=00, busy=0, value=0000 for 10 cycles.
REQ-032 req=01, value0=1234 -> gnt=01 after 1 edge, value=1234 one edge later; value0->ABCD -> value=ABCD next edge.
REQ-033 req=11 from IDLE after reset -> gnt=01; hold both -> gnt=10 after 5 edges in OWN0, gnt=01 after 5 more; never 11 or 00 between.
REQ-034 OWN0, req 01->10 -> gnt=10 on next edge, counter restarted.
REQ-035 OWN1, req->00 -> IDLE; value=5A5A (last value1) with DISP_ARB_HOLD_LAST_EN, 0000 without.
REQ-036 rst_n low mid-OWN1 -> gnt=00, value=0000 immediately without clock; release with req=11 -> gnt=01.
